// File: rtl/atm_pkg.sv
// Shared ATM types: FSM states, dispenser error codes and note values.
// Pure declarations; no logic or latency of its own.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAN,
    ST_FEED,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_INVALID = 2'b01;
  localparam logic [1:0] ERR_NOTES   = 2'b10;
  localparam logic [1:0] ERR_JAM     = 2'b11;

  localparam int unsigned NOTE_1000 = 1000;
  localparam int unsigned NOTE_100  = 100;

endpackage

// File: rtl/dispense_planner.sv
// Greedy 1000/100 decomposition, one note per cycle; ready is asserted in the
// decision cycle (p+1 cycles after start). No backpressure: start restarts it.
module dispense_planner
  import atm_pkg::*;
#(
  parameter int B_WIDTH = 20,
  parameter int N_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [B_WIDTH-1:0] amount,
  input  logic [N_WIDTH-1:0] avail_1000,
  input  logic [N_WIDTH-1:0] avail_100,
  output logic               ready,
  output logic               ok,
  output logic [1:0]         err,
  output logic [N_WIDTH-1:0] k1000,
  output logic [N_WIDTH-1:0] k100
);

  logic               running;
  logic               amt_zero;
  logic [B_WIDTH-1:0] rem;
  logic               take_1000;
  logic               take_100;

  assign take_1000 = running && (rem >= B_WIDTH'(NOTE_1000)) && (k1000 < avail_1000);
  assign take_100  = running && !take_1000 && (rem >= B_WIDTH'(NOTE_100)) && (k100 < avail_100);
  assign ready     = running && !take_1000 && !take_100;
  assign ok        = ready && (rem == '0) && !amt_zero;

  always_comb begin
    err = ERR_NONE;
    if (amt_zero || ((rem != '0) && (rem < B_WIDTH'(NOTE_100))))
      err = ERR_INVALID;
    else if (rem >= B_WIDTH'(NOTE_100))
      err = ERR_NOTES;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      amt_zero <= 1'b0;
      rem      <= '0;
      k1000    <= '0;
      k100     <= '0;
    end else if (start) begin
      running  <= 1'b1;
      amt_zero <= (amount == '0);
      rem      <= amount;
      k1000    <= '0;
      k100     <= '0;
    end else if (take_1000) begin
      rem   <= rem - B_WIDTH'(NOTE_1000);
      k1000 <= k1000 + N_WIDTH'(1);
    end else if (take_100) begin
      rem  <= rem - B_WIDTH'(NOTE_100);
      k100 <= k100 + N_WIDTH'(1);
    end else if (ready) begin
      running <= 1'b0;
    end
  end

endmodule

// File: rtl/cash_dispenser.sv
// Plans a withdrawal, then feeds notes one at a time, each awaiting the exit
// sensor under a watchdog; requests and refills are ignored while busy.
module cash_dispenser
  import atm_pkg::*;
#(
  parameter int B_WIDTH     = 20,
  parameter int N_WIDTH     = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dispense_req,
  input  logic [B_WIDTH-1:0] dispense_amount,
  input  logic               load_en,
  input  logic [N_WIDTH-1:0] load_count_1000,
  input  logic [N_WIDTH-1:0] load_count_100,
  input  logic               note_sensor,
  output logic               feed_1000,
  output logic               feed_100,
  output logic               busy,
  output logic               dispense_done,
  output logic               dispense_error,
  output logic [1:0]         err_code,
  output logic [N_WIDTH-1:0] notes_1000,
  output logic [N_WIDTH-1:0] notes_100,
  output logic [B_WIDTH-1:0] dispensed_amount
);

  localparam int WD_W = $clog2(ACK_TIMEOUT + 1);

  state_t             state;
  logic [N_WIDTH-1:0] k1000, k100;
  logic [N_WIDTH-1:0] nxt_k1000, nxt_k100;
  logic               cur_1000;
  logic [WD_W-1:0]    wd;

  logic               plan_start, plan_ready, plan_ok;
  logic [1:0]         plan_err;
  logic [N_WIDTH-1:0] plan_k1000, plan_k100;

  assign plan_start = (state == ST_IDLE) && dispense_req;

  dispense_planner #(.B_WIDTH(B_WIDTH), .N_WIDTH(N_WIDTH)) u_planner (
    .clk        (clk),
    .rst        (rst),
    .start      (plan_start),
    .amount     (dispense_amount),
    .avail_1000 (notes_1000),
    .avail_100  (notes_100),
    .ready      (plan_ready),
    .ok         (plan_ok),
    .err        (plan_err),
    .k1000      (plan_k1000),
    .k100       (plan_k100)
  );

  // Plan counts after retiring the note currently in flight.
  always_comb begin
    nxt_k1000 = k1000;
    nxt_k100  = k100;
    if (cur_1000) nxt_k1000 = k1000 - N_WIDTH'(1);
    else          nxt_k100  = k100 - N_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      feed_1000        <= 1'b0;
      feed_100         <= 1'b0;
      busy             <= 1'b0;
      dispense_done    <= 1'b0;
      dispense_error   <= 1'b0;
      err_code         <= ERR_NONE;
      notes_1000       <= '0;
      notes_100        <= '0;
      dispensed_amount <= '0;
      k1000            <= '0;
      k100             <= '0;
      cur_1000         <= 1'b0;
      wd               <= '0;
    end else begin
      feed_1000      <= 1'b0;
      feed_100       <= 1'b0;
      dispense_done  <= 1'b0;
      dispense_error <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (load_en) begin
            notes_1000 <= load_count_1000;
            notes_100  <= load_count_100;
          end
          if (dispense_req) begin
            dispensed_amount <= '0;
            err_code         <= ERR_NONE;
            k1000            <= '0;
            k100             <= '0;
            busy             <= 1'b1;
            state            <= ST_PLAN;
          end
        end
        ST_PLAN: begin
          if (plan_ready) begin
            if (plan_ok) begin
              k1000     <= plan_k1000;
              k100      <= plan_k100;
              cur_1000  <= (plan_k1000 != '0);
              feed_1000 <= (plan_k1000 != '0);
              feed_100  <= (plan_k1000 == '0);
              state     <= ST_FEED;
            end else begin
              err_code       <= plan_err;
              dispense_error <= 1'b1;
              state          <= ST_ERROR;
            end
          end
        end
        ST_FEED: begin
          wd    <= '0;
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (note_sensor) begin
            k1000 <= nxt_k1000;
            k100  <= nxt_k100;
            if (cur_1000) begin
              notes_1000       <= notes_1000 - N_WIDTH'(1);
              dispensed_amount <= dispensed_amount + B_WIDTH'(NOTE_1000);
            end else begin
              notes_100        <= notes_100 - N_WIDTH'(1);
              dispensed_amount <= dispensed_amount + B_WIDTH'(NOTE_100);
            end
            if ((nxt_k1000 == '0) && (nxt_k100 == '0)) begin
              dispense_done <= 1'b1;
              state         <= ST_DONE;
            end else begin
              cur_1000  <= (nxt_k1000 != '0);
              feed_1000 <= (nxt_k1000 != '0);
              feed_100  <= (nxt_k1000 == '0);
              state     <= ST_FEED;
            end
          end else if (wd == WD_W'(ACK_TIMEOUT - 1)) begin
            err_code       <= ERR_JAM;
            dispense_error <= 1'b1;
            state          <= ST_ERROR;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        ST_DONE, ST_ERROR: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cash_dispenser.sv
// Directed bench for cash_dispenser: table of whole transactions with
// hand-computed results, plus hand-written busy/stray/reset sequences.
module tb_cash_dispenser;
  localparam int BW = 20;
  localparam int NW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          dispense_req;
  logic [BW-1:0] dispense_amount;
  logic          load_en;
  logic [NW-1:0] load_count_1000, load_count_100;
  logic          note_sensor;
  logic          feed_1000, feed_100, busy, dispense_done, dispense_error;
  logic [1:0]    err_code;
  logic [NW-1:0] notes_1000, notes_100;
  logic [BW-1:0] dispensed_amount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cash_dispenser #(.B_WIDTH(BW), .N_WIDTH(NW), .ACK_TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .dispense_req     (dispense_req),
    .dispense_amount  (dispense_amount),
    .load_en          (load_en),
    .load_count_1000  (load_count_1000),
    .load_count_100   (load_count_100),
    .note_sensor      (note_sensor),
    .feed_1000        (feed_1000),
    .feed_100         (feed_100),
    .busy             (busy),
    .dispense_done    (dispense_done),
    .dispense_error   (dispense_error),
    .err_code         (err_code),
    .notes_1000       (notes_1000),
    .notes_100        (notes_100),
    .dispensed_amount (dispensed_amount)
  );

  typedef struct {
    bit         load;
    int         l1000, l100;
    int         amount;
    int         delay;     // cycles from feed pulse to note_sensor
    int         acks;      // how many feeds get acknowledged
    logic [1:0] code;      // 0 means success expected
    int         end_cyc;   // cycle of done/error pulse, request in cycle 0
    int         f1000, f100;
    logic [15:0] seq;      // feed order, 1 = 1000 note, newest in bit 0
    int         n1000, n100;
    int         paid;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_for(input int sel, input string name);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 100) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       hit = feed_1000 | feed_100;
        1:       hit = dispense_done;
        default: hit = dispense_error;
      endcase
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, f1k, f1h, acks, ack_at, end_cyc;
    logic [15:0] seq;
    bit done_seen, err_seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    cyc = 0; f1k = 0; f1h = 0; acks = 0; ack_at = -1; end_cyc = -1;
    seq = '0; done_seen = 1'b0; err_seen = 1'b0;
    @(negedge clk);
    if (v.load) begin
      load_en = 1'b1;
      load_count_1000 = NW'(v.l1000);
      load_count_100 = NW'(v.l100);
    end
    dispense_req = 1'b1;
    dispense_amount = BW'(v.amount);
    while (!(done_seen || err_seen) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      dispense_req = 1'b0;
      load_en = 1'b0;
      if (cyc == 1) chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
      if (feed_1000 || feed_100) begin
        if (feed_1000) f1k++; else f1h++;
        seq = {seq[14:0], feed_1000};
        if (acks < v.acks) begin
          ack_at = cyc + v.delay;
          acks++;
        end
      end
      done_seen = dispense_done;
      err_seen = dispense_error;
      if (done_seen || err_seen) end_cyc = cyc;
      note_sensor = (ack_at == cyc);
    end
    note_sensor = 1'b0;
    chk({tag, "_done"}, 32'(done_seen), 32'(v.code == 2'b00));
    chk({tag, "_error"}, 32'(err_seen), 32'(v.code != 2'b00));
    chk({tag, "_end_cycle"}, 32'(end_cyc), 32'(v.end_cyc));
    chk({tag, "_feeds_1000"}, 32'(f1k), 32'(v.f1000));
    chk({tag, "_feeds_100"}, 32'(f1h), 32'(v.f100));
    chk({tag, "_feed_order"}, 32'(seq), 32'(v.seq));
    @(negedge clk);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'(v.code));
    chk({tag, "_notes_1000"}, 32'(notes_1000), 32'(v.n1000));
    chk({tag, "_notes_100"}, 32'(notes_100), 32'(v.n100));
    chk({tag, "_paid"}, 32'(dispensed_amount), 32'(v.paid));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int idle_busy;
    //        load l1k l1h  amt  dly acks code end f1k f1h seq       n1k n1h paid
    vt[0] = '{1, 5, 10, 2300, 3, 99, 2'd0, 27, 2, 3, 16'b11000, 3, 7, 2300};
    vt[1] = '{0, 0, 0,  250,  3, 99, 2'd1, 4,  0, 0, 16'b0,     3, 7, 0};
    vt[2] = '{0, 0, 0,  0,    3, 99, 2'd1, 2,  0, 0, 16'b0,     3, 7, 0};
    vt[3] = '{1, 1, 2,  1500, 3, 99, 2'd2, 5,  0, 0, 16'b0,     1, 2, 0};
    vt[4] = '{1, 0, 10, 1000, 1, 99, 2'd0, 32, 0, 10, 16'b0,    0, 0, 1000};
    vt[5] = '{1, 9, 9,  1100, 5, 99, 2'd0, 16, 1, 1, 16'b10,    8, 8, 1100};
    vt[6] = '{1, 0, 5,  200,  2, 1,  2'd3, 24, 0, 2, 16'b0,     0, 4, 100};

    rst = 1'b1;
    dispense_req = 1'b0;
    dispense_amount = '0;
    load_en = 1'b0;
    load_count_1000 = '0;
    load_count_100 = '0;
    note_sensor = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs",
        32'({feed_1000, feed_100, busy, dispense_done, dispense_error, err_code}), 32'd0);
    chk("reset_inventory", 32'({notes_1000, notes_100}), 32'd0);
    chk("reset_paid", 32'(dispensed_amount), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // Stray sensor pulse in IDLE; inventory is 0/4 here.
    @(negedge clk);
    note_sensor = 1'b1;
    @(negedge clk);
    note_sensor = 1'b0;
    @(negedge clk);
    chk("stray_sensor_notes_100", 32'(notes_100), 32'd4);
    chk("stray_sensor_busy", 32'(busy), 32'd0);

    // Refill on its own.
    load_en = 1'b1;
    load_count_1000 = 8'd3;
    load_count_100 = 8'd3;
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    chk("load_only", 32'({notes_1000, notes_100}), 32'({8'd3, 8'd3}));

    // Request and refill while busy are ignored.
    dispense_req = 1'b1;
    dispense_amount = BW'(100);
    @(negedge clk);
    dispense_amount = BW'(5000);
    load_en = 1'b1;
    load_count_1000 = 8'd7;
    load_count_100 = 8'd7;
    @(negedge clk);
    dispense_req = 1'b0;
    load_en = 1'b0;
    wait_for(0, "busy_req_feed");
    @(negedge clk);
    note_sensor = 1'b1;
    @(negedge clk);
    note_sensor = 1'b0;
    chk("busy_req_done", 32'(dispense_done), 32'd1);
    @(negedge clk);
    chk("busy_req_notes", 32'({notes_1000, notes_100}), 32'({8'd3, 8'd2}));
    chk("busy_req_paid", 32'(dispensed_amount), 32'd100);
    idle_busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) idle_busy++;
    end
    chk("busy_req_no_second_txn", 32'(idle_busy), 32'd0);

    // Reset while waiting for the sensor.
    dispense_req = 1'b1;
    dispense_amount = BW'(100);
    @(negedge clk);
    dispense_req = 1'b0;
    wait_for(0, "rst_mid_feed");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_outputs",
        32'({feed_1000, feed_100, busy, dispense_done, dispense_error, err_code}), 32'd0);
    chk("rst_mid_inventory", 32'({notes_1000, notes_100}), 32'd0);
    chk("rst_mid_paid", 32'(dispensed_amount), 32'd0);
    @(negedge clk);
    chk("rst_mid_no_feed", 32'({feed_1000, feed_100, busy}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cash_dispenser.md
# cash_dispenser

Converts an approved withdrawal from the ATM FSM into physical note feeds on the dispenser mechanism. It is the output end of the withdraw path, the counterpart of the deposit/entry side. It greedily decomposes the amount into 1000- and 100-unit notes against its own inventory, then feeds notes one at a time. Each feed waits for the note-exit sensor under a watchdog. Results go back to the FSM as done or error pulses.

## Interface
- B_WIDTH, 20, width of amounts (matches balance width)
- N_WIDTH, 8, width of each note-inventory counter
- ACK_TIMEOUT, 16, cycles to wait for note_sensor after a feed before declaring a jam
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dispense_req  in  1  one-cycle request; sampled only in IDLE
- dispense_amount  in  B_WIDTH  amount to pay; latched with dispense_req
- load_en  in  1  refill strobe; effective only in IDLE
- load_count_1000  in  N_WIDTH  new 1000-note inventory
- load_count_100  in  N_WIDTH  new 100-note inventory
- note_sensor  in  1  one-cycle pulse: one note physically exited
- feed_1000  out  1  one-cycle command: feed one 1000 note
- feed_100  out  1  one-cycle command: feed one 100 note
- busy  out  1  high in every state except IDLE
- dispense_done  out  1  one-cycle success pulse
- dispense_error  out  1  one-cycle failure pulse
- err_code  out  2  00 none, 01 invalid amount, 10 insufficient notes, 11 jam; held until next accepted request
- notes_1000, notes_100  out  N_WIDTH  current inventory
- dispensed_amount  out  B_WIDTH  value confirmed paid in current/last transaction

## Operation
- States: IDLE, PLAN, FEED, WAIT_ACK, DONE, ERROR.
- IDLE:
  - load_en overwrites inventory.
  - dispense_req latches the amount into rem, clears the plan counts k1000/k100, dispensed_amount and err_code, then goes to PLAN.
  - If load_en and dispense_req arrive together, both take effect; PLAN uses the new inventory.
- PLAN, one step per cycle:
  - If rem ≥ 1000 and k1000 < notes_1000: rem −= 1000, k1000++.
  - Else if rem ≥ 100 and k100 < notes_100: rem −= 100, k100++.
  - Else finish:
    - amount == 0 or (0 < rem < 100) → ERROR, code 01.
    - rem ≥ 100 → ERROR, code 10.
    - rem == 0 → FEED.
  - Greedy is optimal because 100 divides 1000.
  - No note is fed unless the whole amount is satisfiable; the plan is atomic.
- FEED: asserts feed_1000 if k1000 > 0, else feed_100, for exactly one cycle. Clears the watchdog and goes to WAIT_ACK.
- WAIT_ACK, on note_sensor:
  - Decrement the matching inventory and plan count.
  - Add 1000 or 100 to dispensed_amount.
  - Go to DONE if both plan counts are now 0, else FEED.
- Jam: ACK_TIMEOUT cycles in WAIT_ACK without note_sensor → ERROR, code 11. Inventory and dispensed_amount reflect confirmed notes only.
- note_sensor outside WAIT_ACK is ignored. dispense_req and load_en while busy are ignored.
- DONE and ERROR each last one cycle, pulse their output, then return to IDLE.
- Reset (including mid-transaction):
  - All outputs go to 0 and inventory is 0.
  - State goes to IDLE.
  - No feed pulse is issued in the reset cycle or the cycle after it.

## Timing
- dispense_req at cycle 0 → busy = 1 from cycle 1.
- PLAN lasts p + 1 cycles, where p is the number of notes planned (bounded by notes_1000 + notes_100).
- First feed pulse is the cycle after the PLAN decision.
- note_sensor at cycle t:
  - Next feed pulse at t+1, or dispense_done at t+1.
  - busy is low at t+2.
- Jam: dispense_error pulses ACK_TIMEOUT+1 cycles after the last feed pulse.
- Error from PLAN: dispense_error pulses the cycle after the decision. No feed is ever asserted.

## Structure
- Shared package atm_pkg holds:
  - the state enum;
  - the err_code constants;
  - note values NOTE_1000 = 1000 and NOTE_100 = 100.
- The natural sub-module is dispense_planner: the iterative greedy decomposition, with start/ready handshake and outputs k1000, k100, ok and err.
- The watchdog is an inline counter.

## Test plan
- Load 5×1000 / 10×100; request 2300; ack each feed 3 cycles later → feeds are 1000, 1000, 100, 100, 100. Then dispense_done; inventory 3/7; dispensed_amount 2300.
- Request 250 → dispense_error, err_code 01, no feed pulses, inventory unchanged. Request 0 → same result.
- Inventory 1×1000 / 2×100; request 1500 → err_code 10, no feeds, inventory unchanged.
- Inventory 0×1000 / 10×100; request 1000 → ten feed_100 pulses, done, notes_100 = 0.
- Request 200; ack the first feed only → after ACK_TIMEOUT, err_code 11; notes_100 reduced by 1; dispensed_amount 100.
- Assert rst in WAIT_ACK → next cycle all outputs 0 and busy 0. Also: dispense_req while busy is ignored, and a stray note_sensor in IDLE does not change inventory.
